rd_burst_checker: RTL
=====================

# rd_burst_checker

Read-data checker for the memory tester's Avalon-MM read path. It queues read-burst descriptors issued by the transaction generator and applies first/last-word byte masks to every returned `readdata` beat. Each enabled byte is compared against the expected pattern, and the checker latches the byte address and data of the first mismatch. Data width, burst width and descriptor queue depth are parametrised.

## Interface

- `AMM_DATA_W`, 512: read data width in bits; `DATA_B_W = AMM_DATA_W/8`, `ADDR_B_W = $clog2(DATA_B_W)`.
- `CMP_ADDR_W`, 26: word-address width.
- `AMM_BURST_W`, 11: burst field width; the word count field is `AMM_BURST_W-1` bits.
- `CMD_DEPTH`, 4: descriptor FIFO depth, power of two, ≥2.

Ports:

- `clk_i`  in  1: clock. Single clock domain.
- `rst_n_i`  in  1: reset, asynchronous assert, active-low.
- `clear_i`  in  1: synchronous test restart.
- `cmd_valid_i`  in  1: descriptor valid.
- `cmd_ready_o`  out  1: descriptor FIFO not full.
- `cmd_start_addr_i`  in  CMP_ADDR_W: word address of the first beat.
- `cmd_start_off_i`  in  ADDR_B_W: first enabled byte in the first beat.
- `cmd_end_off_i`  in  ADDR_B_W: last enabled byte in the last beat.
- `cmd_words_i`  in  AMM_BURST_W-1: beats minus one (0 = 1 beat).
- `cmd_data_mode_i`  in  1: 0 = fixed pattern, 1 = address-derived pattern.
- `cmd_data_ptrn_i`  in  8: pattern byte.
- `readdatavalid_i`  in  1: read beat valid.
- `readdata_i`  in  AMM_DATA_W: read beat data.
- `busy_o`  out  1: FIFO non-empty or pipeline occupied.
- `err_o`  out  1: sticky mismatch flag.
- `err_addr_o`  out  CMP_ADDR_W+ADDR_B_W: byte address of first mismatch.
- `err_data_o`  out  8: received byte at first mismatch.
- `err_exp_o`  out  8: expected byte at first mismatch.
- `orphan_o`  out  1: sticky flag, beat arrived with no pending descriptor.
- `rd_words_o`  out  32: beats checked, saturating.

## Operation

Descriptor handling:

- Descriptor FIFO: push on `cmd_valid_i && cmd_ready_o`. Head descriptor is active; a beat counter `beat` runs 0..`cmd_words`.
- Popping the head on its last beat and pushing a new descriptor in the same cycle is legal. With a full FIFO this is still blocked, because `cmd_ready_o` depends only on fill level.

Byte mask per beat, for byte i:

- Single-beat burst: enabled when `start_off ≤ i ≤ end_off`.
- First beat: enabled when `i ≥ start_off`.
- Last beat: enabled when `i ≤ end_off`.
- Middle beats: all bytes enabled.
- `start_off > end_off` on a single-beat burst gives an empty mask: no byte is checked, but the beat still counts.

Beat address and expected data:

- Beat word address = `start_addr + beat`, wrapping modulo 2^CMP_ADDR_W. Byte address = {word address, i}.
- Expected byte: `data_ptrn` in fixed mode; `data_ptrn ^ byte_addr[7:0]` in address mode (see Configuration).

Error capture and counters:

- First error is the lowest enabled mismatching byte index in the earliest failing beat.
- Only the first error since reset or `clear_i` is captured. Later mismatches leave `err_*` unchanged.
- `rd_words_o` increments per accepted beat and saturates at 0xFFFF_FFFF.
- A beat with an empty FIFO sets `orphan_o`, is discarded, and is not counted.

Clear and reset:

- `clear_i` flushes the FIFO, resets `beat`, and drops beats in flight in the pipeline. It clears `err_o`, `err_*`, `orphan_o` and `rd_words_o`.
- `clear_i` takes precedence over a simultaneous push or beat; both are dropped.
- Reset values: `cmd_ready_o` = 1; `busy_o`, `err_o`, `orphan_o` = 0; `err_addr_o`, `err_data_o`, `err_exp_o`, `rd_words_o` = 0.

## Timing

- Pipeline, with the beat accepted in cycle N:
  - Stage 1, N+1: registered data, mask, expected bytes and byte-address base.
  - Stage 2, N+2: registered per-byte check vector and first-index encoder.
  - Capture: `err_o` and `err_*` update at the clock edge ending N+2, visible from N+3.
- `rd_words_o` and `orphan_o` update at the edge ending N and are visible from N+1.
- Throughput is one beat per cycle with no stall. `readdatavalid_i` cannot be back-pressured.
- `cmd_ready_o` is registered and deasserts the cycle after the push that fills the FIFO.
- `busy_o` falls the cycle after the last beat leaves stage 2.
- Reset asserted mid-burst: all state clears immediately. `rst_n_i` deassertion is synchronised externally.

## Configuration

- `RD_CHK_ADDR_DATA_EN` defined:
  - `cmd_data_mode_i = 1` selects the address-derived pattern `data_ptrn ^ byte_addr[7:0]`.
  - Stage 1 adds a 64-way XOR byte-address generator.
- Not defined:
  - `cmd_data_mode_i` is ignored and all bytes compare against `data_ptrn`.
  - The address generator is not synthesised.

## Test plan

- Fixed-pattern clean pass:
  - Stimulus: push {addr 0x100, off 0/63, words 3, ptrn 0xA5}; 4 beats of all-0xA5.
  - Response: `err_o` = 0, `rd_words_o` = 4, `busy_o` low 3 cycles after the last beat.
- Masked edges:
  - Stimulus: push {start_off 10, end_off 5, words 1, ptrn 0x3C}. Beat 0 has bytes 0..9 = 0x00, others 0x3C; beat 1 has bytes 6..63 = 0xFF, others 0x3C.
  - Response: `err_o` = 0.
- First error capture:
  - Stimulus: push {addr 0x2, words 2}; beat 1 byte 17 = 0x11 and byte 40 = 0x22; beat 2 byte 0 bad.
  - Response: `err_addr_o` = 0x3·64+17 = 0xD1, `err_data_o` = 0x11, `err_exp_o` = 0xA5; later errors ignored.
- Address wrap and address mode (`RD_CHK_ADDR_DATA_EN` defined):
  - Stimulus: push {addr 2^26-1, words 1, mode 1, ptrn 0x00}; beats carry byte address low bits.
  - Response: no error; second beat uses word address 0.
- Back-pressure, orphan and clear:
  - Stimulus: push 5 one-beat descriptors back-to-back with `CMD_DEPTH`=4.
    - Response: `cmd_ready_o` = 0 after the fourth.
  - Stimulus: 5 beats.
    - Response: `orphan_o` = 1, `rd_words_o` = 4.
  - Stimulus: `clear_i`.
    - Response: all flags and counters return to 0.

Source files
------------

// File: rtl/rd_burst_checker.sv
// Read-data checker: queues read-burst descriptors, masks and compares returned beats, and
// latches the first mismatching byte. Optional macro RD_CHK_ADDR_DATA_EN enables the address-derived pattern.
`timescale 1ns / 1ps

module rd_burst_checker #(
  parameter int unsigned AMM_DATA_W  = 512,
  parameter int unsigned CMP_ADDR_W  = 26,
  parameter int unsigned AMM_BURST_W = 11,
  parameter int unsigned CMD_DEPTH   = 4,
  localparam int unsigned DATA_B_W   = AMM_DATA_W / 8,
  localparam int unsigned ADDR_B_W   = $clog2(DATA_B_W)
) (
  input  logic                           clk_i,
  input  logic                           rst_n_i,
  input  logic                           clear_i,
  input  logic                           cmd_valid_i,
  output logic                           cmd_ready_o,
  input  logic [CMP_ADDR_W-1:0]          cmd_start_addr_i,
  input  logic [ADDR_B_W-1:0]            cmd_start_off_i,
  input  logic [ADDR_B_W-1:0]            cmd_end_off_i,
  input  logic [AMM_BURST_W-2:0]         cmd_words_i,
  input  logic                           cmd_data_mode_i,
  input  logic [7:0]                     cmd_data_ptrn_i,
  input  logic                           readdatavalid_i,
  input  logic [AMM_DATA_W-1:0]          readdata_i,
  output logic                           busy_o,
  output logic                           err_o,
  output logic [CMP_ADDR_W+ADDR_B_W-1:0] err_addr_o,
  output logic [7:0]                     err_data_o,
  output logic [7:0]                     err_exp_o,
  output logic                           orphan_o,
  output logic [31:0]                    rd_words_o
);

  localparam int unsigned WCNT_W = AMM_BURST_W - 1;
  localparam int unsigned PTR_W  = $clog2(CMD_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;

  typedef struct packed {
    logic [CMP_ADDR_W-1:0] addr;
    logic [ADDR_B_W-1:0]   soff;
    logic [ADDR_B_W-1:0]   eoff;
    logic [WCNT_W-1:0]     words;
`ifdef RD_CHK_ADDR_DATA_EN
    logic                  mode;
`endif
    logic [7:0]            ptrn;
  } desc_t;

  desc_t cmd_desc, head;
  desc_t mem_q [CMD_DEPTH];

  logic [CNT_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, fifo_cnt, cnt_next;
  logic              ready_q, ready_d;
  logic [WCNT_W-1:0] beat_q, beat_d;
  logic              fifo_empty, push, pop, beat_acc, orphan_set, last_beat;

  logic [CMP_ADDR_W-1:0] beat_addr;
  logic [DATA_B_W-1:0]   mask;
  logic [AMM_DATA_W-1:0] exp_data;

  logic                  s1_valid_q;
  logic [AMM_DATA_W-1:0] s1_data_q, s1_exp_q;
  logic [DATA_B_W-1:0]   s1_mask_q;
  logic [CMP_ADDR_W-1:0] s1_addr_q;

  logic                  s2_valid_q;
  logic [DATA_B_W-1:0]   s2_bad_q, s2_bad_d;
  logic [AMM_DATA_W-1:0] s2_data_q, s2_exp_q;
  logic [CMP_ADDR_W-1:0] s2_addr_q;

  logic [ADDR_B_W-1:0]   first_idx;
  logic [7:0]            first_data, first_exp;
  logic                  err_set;

  logic                           err_q, orphan_q;
  logic [CMP_ADDR_W+ADDR_B_W-1:0] err_addr_q;
  logic [7:0]                     err_data_q, err_exp_q;
  logic [31:0]                    rd_words_q, rd_words_d;

  always_comb begin
    cmd_desc.addr  = cmd_start_addr_i;
    cmd_desc.soff  = cmd_start_off_i;
    cmd_desc.eoff  = cmd_end_off_i;
    cmd_desc.words = cmd_words_i;
`ifdef RD_CHK_ADDR_DATA_EN
    cmd_desc.mode  = cmd_data_mode_i;
`endif
    cmd_desc.ptrn  = cmd_data_ptrn_i;
  end

`ifndef RD_CHK_ADDR_DATA_EN
  logic unused_mode;
  assign unused_mode = cmd_data_mode_i;
`endif

  assign fifo_cnt   = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (fifo_cnt == '0);
  assign head       = mem_q[rd_ptr_q[PTR_W-1:0]];
  assign last_beat  = (beat_q == head.words);
  assign push       = cmd_valid_i && ready_q && !clear_i;
  assign beat_acc   = readdatavalid_i && !fifo_empty && !clear_i;
  assign orphan_set = readdatavalid_i && fifo_empty && !clear_i;
  assign pop        = beat_acc && last_beat;

  // Descriptor storage holds no reset; only entries between the pointers are ever read.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= cmd_desc;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + CNT_W'(push);
    rd_ptr_d = rd_ptr_q + CNT_W'(pop);
    cnt_next = fifo_cnt + CNT_W'(push) - CNT_W'(pop);
    ready_d  = (cnt_next != CNT_W'(CMD_DEPTH));
    beat_d   = beat_q;
    if (beat_acc) beat_d = last_beat ? '0 : beat_q + 1'b1;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ready_d  = 1'b1;
      beat_d   = '0;
    end
  end

  // Stage 1 inputs: byte mask, beat address and expected bytes for the head descriptor.
  always_comb begin
    beat_addr = head.addr + CMP_ADDR_W'(beat_q);
    mask      = '0;
    exp_data  = '0;
    for (int i = 0; i < DATA_B_W; i++) begin
      mask[i] = ((beat_q != '0) || (ADDR_B_W'(i) >= head.soff)) &&
                (!last_beat || (ADDR_B_W'(i) <= head.eoff));
`ifdef RD_CHK_ADDR_DATA_EN
      exp_data[i*8 +: 8] = head.mode ? (head.ptrn ^ 8'({beat_addr, ADDR_B_W'(i)})) : head.ptrn;
`else
      exp_data[i*8 +: 8] = head.ptrn;
`endif
    end
  end

  always_comb begin
    s2_bad_d = '0;
    for (int i = 0; i < DATA_B_W; i++) begin
      s2_bad_d[i] = s1_mask_q[i] && (s1_data_q[i*8 +: 8] != s1_exp_q[i*8 +: 8]);
    end
  end

  // Descending scan so the lowest failing byte index wins.
  always_comb begin
    first_idx  = '0;
    first_data = '0;
    first_exp  = '0;
    for (int i = DATA_B_W - 1; i >= 0; i--) begin
      if (s2_bad_q[i]) begin
        first_idx  = ADDR_B_W'(i);
        first_data = s2_data_q[i*8 +: 8];
        first_exp  = s2_exp_q[i*8 +: 8];
      end
    end
  end

  assign err_set = s2_valid_q && (s2_bad_q != '0) && !err_q && !clear_i;

  always_comb begin
    rd_words_d = rd_words_q;
    if (clear_i) rd_words_d = '0;
    else if (beat_acc && (rd_words_q != '1)) rd_words_d = rd_words_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ready_q    <= 1'b1;
      beat_q     <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_exp_q   <= '0;
      s1_mask_q  <= '0;
      s1_addr_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_bad_q   <= '0;
      s2_data_q  <= '0;
      s2_exp_q   <= '0;
      s2_addr_q  <= '0;
      err_q      <= 1'b0;
      err_addr_q <= '0;
      err_data_q <= '0;
      err_exp_q  <= '0;
      orphan_q   <= 1'b0;
      rd_words_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ready_q    <= ready_d;
      beat_q     <= beat_d;
      rd_words_q <= rd_words_d;
      s1_valid_q <= beat_acc;
      if (beat_acc) begin
        s1_data_q <= readdata_i;
        s1_exp_q  <= exp_data;
        s1_mask_q <= mask;
        s1_addr_q <= beat_addr;
      end
      s2_valid_q <= s1_valid_q && !clear_i;
      if (s1_valid_q) begin
        s2_bad_q  <= s2_bad_d;
        s2_data_q <= s1_data_q;
        s2_exp_q  <= s1_exp_q;
        s2_addr_q <= s1_addr_q;
      end
      if (clear_i) begin
        err_q      <= 1'b0;
        err_addr_q <= '0;
        err_data_q <= '0;
        err_exp_q  <= '0;
        orphan_q   <= 1'b0;
      end else begin
        if (orphan_set) orphan_q <= 1'b1;
        if (err_set) begin
          err_q      <= 1'b1;
          err_addr_q <= {s2_addr_q, first_idx};
          err_data_q <= first_data;
          err_exp_q  <= first_exp;
        end
      end
    end
  end

  assign cmd_ready_o = ready_q;
  assign busy_o      = !fifo_empty || s1_valid_q || s2_valid_q;
  assign err_o       = err_q;
  assign err_addr_o  = err_addr_q;
  assign err_data_o  = err_data_q;
  assign err_exp_o   = err_exp_q;
  assign orphan_o    = orphan_q;
  assign rd_words_o  = rd_words_q;

endmodule
